serial_divider: RTL and testbench



---
 rtl/serial_divider_pkg.sv | 18 +
 rtl/serial_div_step.sv | 22 ++
 rtl/serial_divider.sv | 135 +++++++++++++
 tb/tb_serial_divider.sv | 168 ++++++++++++++++
 4 files changed

// File: rtl/serial_divider_pkg.sv
// Shared arithmetic definitions for the serial multiply/divide pair.
package serial_divider_pkg;

    typedef enum logic [1:0] {StIdle, StRun, StFix} div_state_e;

    localparam int unsigned MaxWidth = 64;

    function automatic int unsigned div_cnt_w(input int unsigned width);
        return $clog2(width + 1);
    endfunction

    // Two's-complement negate when neg is set; callers zero-extend and truncate to their width.
    function automatic logic [MaxWidth-1:0] cond_negate(input logic [MaxWidth-1:0] v,
                                                        input logic neg);
        return neg ? (~v + MaxWidth'(1)) : v;
    endfunction

endpackage

// File: rtl/serial_div_step.sv
// One restoring-division slice: shift in a dividend bit, trial-subtract the divisor.
module serial_div_step #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem_in,
    input  logic             dvd_bit,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_out,
    output logic             q_bit
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] trial;

    always_comb begin
        shifted = {rem_in, dvd_bit};
        trial   = shifted - {1'b0, divisor};
        q_bit   = ~trial[WIDTH];
        rem_out = q_bit ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
    end

endmodule

// File: rtl/serial_divider.sv
// Sequential signed divider, one quotient bit per clock, with start/done handshake.
module serial_divider
    import serial_divider_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] DD,
    input  logic [WIDTH-1:0] DS,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] R,
    output logic             busy,
    output logic             done,
    output logic             dbz
);

    localparam int unsigned CntW = div_cnt_w(WIDTH);

    div_state_e       state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] ds_q, ds_d;
    logic             neg_q_q, neg_q_d;
    logic             neg_r_q, neg_r_d;
    logic             zero_q, zero_d;
    logic [WIDTH-1:0] quot_q, quot_d;
    logic [WIDTH-1:0] remo_q, remo_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             dbz_q, dbz_d;

    logic [WIDTH-1:0] step_rem;
    logic             step_bit;

    serial_div_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .rem_in  (rem_q),
        .dvd_bit (dvd_q[WIDTH-1]),
        .divisor (ds_q),
        .rem_out (step_rem),
        .q_bit   (step_bit)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rem_d   = rem_q;
        dvd_d   = dvd_q;
        ds_d    = ds_q;
        neg_q_d = neg_q_q;
        neg_r_d = neg_r_q;
        zero_d  = zero_q;
        quot_d  = quot_q;
        remo_d  = remo_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        dbz_d   = dbz_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    dvd_d   = WIDTH'(cond_negate(MaxWidth'(DD), DD[WIDTH-1]));
                    ds_d    = WIDTH'(cond_negate(MaxWidth'(DS), DS[WIDTH-1]));
                    neg_q_d = DD[WIDTH-1] ^ DS[WIDTH-1];
                    neg_r_d = DD[WIDTH-1];
                    zero_d  = (DS == '0);
                    rem_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = StRun;
                end
            end
            StRun: begin
                // The dividend register doubles as the quotient accumulator.
                dvd_d = {dvd_q[WIDTH-2:0], step_bit};
                rem_d = step_rem;
                cnt_d = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                quot_d  = zero_q ? '1 : WIDTH'(cond_negate(MaxWidth'(dvd_q), neg_q_q));
                remo_d  = WIDTH'(cond_negate(MaxWidth'(rem_q), neg_r_q));
                dbz_d   = zero_q;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            rem_q   <= '0;
            dvd_q   <= '0;
            ds_q    <= '0;
            neg_q_q <= 1'b0;
            neg_r_q <= 1'b0;
            zero_q  <= 1'b0;
            quot_q  <= '0;
            remo_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rem_q   <= rem_d;
            dvd_q   <= dvd_d;
            ds_q    <= ds_d;
            neg_q_q <= neg_q_d;
            neg_r_q <= neg_r_d;
            zero_q  <= zero_d;
            quot_q  <= quot_d;
            remo_q  <= remo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dbz_q   <= dbz_d;
        end
    end

    assign Q    = quot_q;
    assign R    = remo_q;
    assign busy = busy_q;
    assign done = done_q;
    assign dbz  = dbz_q;

endmodule

// File: tb/tb_serial_divider.sv
// Randomised and directed checks of serial_divider against a plain-arithmetic signed model.
module tb_serial_divider;

    localparam int unsigned W = 32;
    localparam int unsigned Latency = W + 1;

    logic         clk;
    logic         rst;
    logic         start;
    logic [W-1:0] DD;
    logic [W-1:0] DS;
    logic [W-1:0] Q;
    logic [W-1:0] R;
    logic         busy;
    logic         done;
    logic         dbz;

    int checks = 0;
    int errors = 0;

    serial_divider #(
        .WIDTH (W)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .DD    (DD),
        .DS    (DS),
        .Q     (Q),
        .R     (R),
        .busy  (busy),
        .done  (done),
        .dbz   (dbz)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Signed division truncating toward zero; remainder follows the dividend.
    function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                  output logic [W-1:0] q, output logic [W-1:0] r,
                                  output logic z);
        longint sa, sb, lq, lr;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        if (sb == 0) begin
            q = '1;
            r = a;
            z = 1'b1;
        end else begin
            lq = sa / sb;
            lr = sa - lq * sb;
            q  = lq[W-1:0];
            r  = lr[W-1:0];
            z  = 1'b0;
        end
    endfunction

    // Issue one division and follow it to done; optionally re-pulse start at cycle repulse_at.
    task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b, input int repulse_at);
        logic [W-1:0] eq, er;
        logic         ez;
        int           n;
        model(a, b, eq, er, ez);
        @(negedge clk);
        start = 1'b1;
        DD    = a;
        DS    = b;
        @(negedge clk);
        start = 1'b0;
        DD    = $urandom;
        DS    = $urandom;
        check_eq("busy_after_accept", busy, 1);
        n = 0;
        while (!done && n < Latency + 5) begin
            if (n == repulse_at) begin
                start = 1'b1;
                DD    = 1;
                DS    = 1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
            if (!done) check_eq("busy_during_run", busy, 1);
        end
        start = 1'b0;
        check_eq("latency", n, Latency);
        check_eq("quotient", Q, eq);
        check_eq("remainder", R, er);
        check_eq("dbz", dbz, ez);
        check_eq("busy_at_done", busy, 0);
        @(negedge clk);
        check_eq("done_single_pulse", done, 0);
        check_eq("quotient_held", Q, eq);
    endtask

    initial begin
        logic [W-1:0] ra, rb;
        rst   = 1'b0;
        start = 1'b0;
        DD    = '0;
        DS    = '0;
        repeat (2) @(negedge clk);
        check_eq("reset_q", Q, 0);
        check_eq("reset_r", R, 0);
        check_eq("reset_busy", busy, 0);
        check_eq("reset_done", done, 0);
        check_eq("reset_dbz", dbz, 0);
        rst = 1'b1;

        run_div(32'd100, 32'd7, -1);
        run_div(-32'sd100, 32'd7, -1);
        run_div(32'd100, -32'sd7, -1);
        run_div(-32'sd100, -32'sd7, -1);
        run_div(32'd5, 32'd0, -1);
        run_div(32'd9, 32'd3, -1);
        run_div(32'h8000_0000, 32'hFFFF_FFFF, -1);
        run_div(32'd0, -32'sd5, -1);
        run_div(-32'sd5, 32'd0, -1);
        run_div(32'd100, 32'd7, 9);

        // Asynchronous reset in the middle of a division.
        @(negedge clk);
        start = 1'b1;
        DD    = 32'd100;
        DS    = 32'd7;
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        check_eq("busy_before_rst", busy, 1);
        #2 rst = 1'b0;
        #1;
        check_eq("rst_busy", busy, 0);
        check_eq("rst_done", done, 0);
        check_eq("rst_q", Q, 0);
        check_eq("rst_r", R, 0);
        repeat (Latency + 2) begin
            @(negedge clk);
            check_eq("no_done_in_rst", done, 0);
        end
        rst = 1'b1;
        run_div(32'd100, 32'd7, -1);

        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            unique case (i % 4)
                0: rb = $urandom;
                1: rb = $urandom_range(1, 20);
                2: rb = -$urandom_range(1, 20);
                default: rb = (i % 8 == 3) ? '0 : ($urandom >> $urandom_range(0, 31));
            endcase
            run_div(ra, rb, (i % 5 == 0) ? int'($urandom_range(0, Latency - 1)) : -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
